// File: rtl/mig7_ui_model.sv
// mig7_ui_model: stands in for the MIG7 controller on the app_* user
// interface. A small on-chip memory (2^MEM_AW words of 128 bits) replaces
// the DDR3, so the initiator can be brought up without a memory model.
//
// Ports
//   i_clk, i_rst_n           UI clock, asynchronous active-low reset
//   i_app_addr/cmd/en        command channel (000 write, 001 read)
//   i_app_wdf_*              write-data channel {data, mask}, mask 1 = keep byte
//   o_app_rd_data*           read return, one beat per read, in command order
//   o_app_rdy, o_app_wdf_rdy accept strobes for the two input channels
//   i_app_sr_req             self-refresh, not supported (ignored)
//   i_app_ref_req/zq_req     maintenance requests, acked by o_app_ref/zq_ack
//   o_app_sr_active          always 0
//   o_init_calib_complete    high CALIB_CYCLES cycles after reset release
//   o_dbg_maint_state        maintenance FSM state, for checkers
//
// Handshake: a transfer happens on a channel in every cycle where its valid
// (i_app_en / i_app_wdf_wren) and its ready (o_app_rdy / o_app_wdf_rdy) are
// both high at the rising clock edge. Ready never depends on valid in the
// same cycle.

// Small synchronous FIFO; DEPTH must be a power of two, at least 2.
module mig7_ui_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (i_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  // Extra pointer bit distinguishes full from empty.
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
endmodule

module mig7_ui_model #(
  parameter int MEM_AW       = 8,
  parameter int CALIB_CYCLES = 64,
  parameter int RD_LATENCY   = 4,
  parameter int CMD_DEPTH    = 4,
  parameter int WDF_DEPTH    = 4,
  parameter int MAINT_CYCLES = 16,
  parameter int STALL_PERIOD = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [27:0]  i_app_addr,
  input  logic [2:0]   i_app_cmd,
  input  logic         i_app_en,
  input  logic [127:0] i_app_wdf_data,
  input  logic         i_app_wdf_end,
  input  logic [15:0]  i_app_wdf_mask,
  input  logic         i_app_wdf_wren,
  output logic [127:0] o_app_rd_data,
  output logic         o_app_rd_data_end,
  output logic         o_app_rd_data_valid,
  output logic         o_app_rdy,
  output logic         o_app_wdf_rdy,
  input  logic         i_app_sr_req,
  input  logic         i_app_ref_req,
  input  logic         i_app_zq_req,
  output logic         o_app_sr_active,
  output logic         o_app_ref_ack,
  output logic         o_app_zq_ack,
  output logic         o_init_calib_complete,
  output logic [1:0]   o_dbg_maint_state
);
  localparam int CCW = $clog2(CALIB_CYCLES + 1);
  localparam int MCW = $clog2(MAINT_CYCLES + 1);

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REF  = 2'd1,
    MS_ZQ   = 2'd2
  } maint_state_t;

  // Only the word index and the command code matter; the rest is dropped.
  logic w_unused_inputs;
  assign w_unused_inputs = ^{i_app_wdf_end, i_app_sr_req,
                             i_app_addr[27:MEM_AW+3], i_app_addr[2:0]};

  // ---------------- calibration ----------------
  logic [CCW-1:0] r_calib_cnt;
  logic           r_calib;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_calib_cnt <= '0;
      r_calib     <= 1'b0;
    end else if (!r_calib) begin
      if (r_calib_cnt == CCW'(CALIB_CYCLES - 1)) r_calib <= 1'b1;
      r_calib_cnt <= r_calib_cnt + CCW'(1);
    end
  end

  // ---------------- stall injection ----------------
  logic w_stall;
  generate
    if (STALL_PERIOD > 0) begin : g_stall
      localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
      logic [SW-1:0] r_stall_cnt;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                               r_stall_cnt <= '0;
        else if (r_stall_cnt == SW'(STALL_PERIOD - 1)) r_stall_cnt <= '0;
        else                                        r_stall_cnt <= r_stall_cnt + SW'(1);
      end
      assign w_stall = (r_stall_cnt == SW'(STALL_PERIOD - 1));
    end else begin : g_no_stall
      assign w_stall = 1'b0;
    end
  endgenerate

  // ---------------- command and write-data FIFOs ----------------
  maint_state_t r_maint_state;
  maint_state_t w_maint_next;
  logic         r_ref_pend;
  logic         r_zq_pend;

  logic              w_cmd_push, w_cmd_pop, w_cmd_empty, w_cmd_full;
  logic [MEM_AW:0]   w_cmd_in, w_cmd_head;
  logic              w_wdf_push, w_wdf_pop, w_wdf_empty, w_wdf_full;
  logic [143:0]      w_wdf_in, w_wdf_head;

  assign o_app_rdy = r_calib & ~w_cmd_full & ~r_ref_pend & ~r_zq_pend &
                     (r_maint_state == MS_IDLE) & ~w_stall;
  assign o_app_wdf_rdy = r_calib & ~w_wdf_full;

  // Unknown command codes are accepted but never reach the FIFO.
  assign w_cmd_push = i_app_en & o_app_rdy &
                      ((i_app_cmd == 3'b000) || (i_app_cmd == 3'b001));
  assign w_cmd_in   = {i_app_cmd[0], i_app_addr[MEM_AW+2:3]};
  assign w_wdf_push = i_app_wdf_wren & o_app_wdf_rdy;
  assign w_wdf_in   = {i_app_wdf_mask, i_app_wdf_data};

  mig7_ui_fifo #(.W(MEM_AW + 1), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_cmd_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_cmd_pop),
    .o_data  (w_cmd_head),
    .o_empty (w_cmd_empty),
    .o_full  (w_cmd_full)
  );

  mig7_ui_fifo #(.W(144), .DEPTH(WDF_DEPTH)) u_wdf_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_wdf_push),
    .i_data  (w_wdf_in),
    .i_pop   (w_wdf_pop),
    .o_data  (w_wdf_head),
    .o_empty (w_wdf_empty),
    .o_full  (w_wdf_full)
  );

  // ---------------- executor and memory ----------------
  logic              w_head_rd;
  logic [MEM_AW-1:0] w_head_idx;
  logic              w_exec_rd;
  logic              w_exec_wr;

  assign w_head_rd  = w_cmd_head[MEM_AW];
  assign w_head_idx = w_cmd_head[MEM_AW-1:0];
  assign w_exec_rd  = ~w_cmd_empty & w_head_rd;
  // A write waits at the head until its data beat is present.
  assign w_exec_wr  = ~w_cmd_empty & ~w_head_rd & ~w_wdf_empty;
  assign w_cmd_pop  = w_exec_rd | w_exec_wr;
  assign w_wdf_pop  = w_exec_wr;

  logic [127:0] r_mem [2**MEM_AW];

  always_ff @(posedge i_clk) begin
    if (w_exec_wr) begin
      for (int b = 0; b < 16; b++) begin
        if (!w_wdf_head[128+b]) r_mem[w_head_idx][8*b +: 8] <= w_wdf_head[8*b +: 8];
      end
    end
  end

  // Stage 0 captures the memory word as the read issues; the last stage
  // drives the outputs, giving RD_LATENCY+1 edges from issue to valid.
  logic [RD_LATENCY:0] r_pipe_vld;
  logic [127:0]        r_pipe_data [RD_LATENCY+1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) r_pipe_data[i] <= '0;
    end else begin
      r_pipe_vld     <= {r_pipe_vld[RD_LATENCY-1:0], w_exec_rd};
      r_pipe_data[0] <= r_mem[w_head_idx];
      for (int i = 1; i <= RD_LATENCY; i++) r_pipe_data[i] <= r_pipe_data[i-1];
    end
  end

  assign o_app_rd_data       = r_pipe_data[RD_LATENCY];
  assign o_app_rd_data_valid = r_pipe_vld[RD_LATENCY];
  assign o_app_rd_data_end   = r_pipe_vld[RD_LATENCY];
  assign o_app_sr_active     = 1'b0;

  // ---------------- maintenance ----------------
  logic [MCW-1:0] r_maint_cnt;
  logic           w_start_ref, w_start_zq, w_end_ref, w_end_zq;
  logic           w_ref_set, w_zq_set;
  logic           r_ref_ack, r_zq_ack;

  // A request of a type already pending or busy merges into that one.
  assign w_ref_set = r_calib & i_app_ref_req & ~r_ref_pend & (r_maint_state != MS_REF);
  assign w_zq_set  = r_calib & i_app_zq_req  & ~r_zq_pend  & (r_maint_state != MS_ZQ);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_maint_state <= MS_IDLE;
    else          r_maint_state <= w_maint_next;
  end

  // Refresh wins over ZQ; the end of one busy period can start the other
  // directly so back-to-back maintenance has no idle gap.
  always_comb begin
    w_maint_next = r_maint_state;
    w_start_ref  = 1'b0;
    w_start_zq   = 1'b0;
    w_end_ref    = 1'b0;
    w_end_zq     = 1'b0;
    case (r_maint_state)
      MS_IDLE: begin
        if (w_cmd_empty) begin
          if (r_ref_pend) begin
            w_maint_next = MS_REF;
            w_start_ref  = 1'b1;
          end else if (r_zq_pend) begin
            w_maint_next = MS_ZQ;
            w_start_zq   = 1'b1;
          end
        end
      end
      MS_REF: begin
        if (r_maint_cnt == '0) begin
          w_end_ref = 1'b1;
          if (r_zq_pend && w_cmd_empty) begin
            w_maint_next = MS_ZQ;
            w_start_zq   = 1'b1;
          end else begin
            w_maint_next = MS_IDLE;
          end
        end
      end
      MS_ZQ: begin
        if (r_maint_cnt == '0) begin
          w_end_zq = 1'b1;
          if (r_ref_pend && w_cmd_empty) begin
            w_maint_next = MS_REF;
            w_start_ref  = 1'b1;
          end else begin
            w_maint_next = MS_IDLE;
          end
        end
      end
      default: w_maint_next = MS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_maint_cnt <= '0;
      r_ref_pend  <= 1'b0;
      r_zq_pend   <= 1'b0;
      r_ref_ack   <= 1'b0;
      r_zq_ack    <= 1'b0;
    end else begin
      if (w_start_ref || w_start_zq) r_maint_cnt <= MCW'(MAINT_CYCLES - 1);
      else if (r_maint_cnt != '0)    r_maint_cnt <= r_maint_cnt - MCW'(1);
      r_ref_pend <= (r_ref_pend & ~w_start_ref) | w_ref_set;
      r_zq_pend  <= (r_zq_pend  & ~w_start_zq)  | w_zq_set;
      r_ref_ack  <= w_end_ref;
      r_zq_ack   <= w_end_zq;
    end
  end

  assign o_app_ref_ack         = r_ref_ack;
  assign o_app_zq_ack          = r_zq_ack;
  assign o_init_calib_complete = r_calib;
  assign o_dbg_maint_state     = r_maint_state;
endmodule

// File: tb/tb_mig7_ui_model.sv
// Bench for mig7_ui_model: directed scenarios plus a randomized mix, read
// data checked against an in-order transaction model of the memory.
module tb_mig7_ui_model;
  localparam int CALIB  = 64;
  localparam int RD_LAT = 4;
  localparam int MAINT  = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [27:0]  app_addr = '0;
  logic [2:0]   app_cmd = '0;
  logic         app_en = 1'b0;
  logic [127:0] app_wdf_data = '0;
  logic         app_wdf_end = 1'b0;
  logic [15:0]  app_wdf_mask = '0;
  logic         app_wdf_wren = 1'b0;
  logic [127:0] app_rd_data;
  logic         app_rd_data_end, app_rd_data_valid, app_rdy, app_wdf_rdy;
  logic         app_sr_req = 1'b0, app_ref_req = 1'b0, app_zq_req = 1'b0;
  logic         app_sr_active, app_ref_ack, app_zq_ack, init_calib_complete;
  logic [1:0]   dbg_maint_state;

  mig7_ui_model dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_app_addr            (app_addr),
    .i_app_cmd             (app_cmd),
    .i_app_en              (app_en),
    .i_app_wdf_data        (app_wdf_data),
    .i_app_wdf_end         (app_wdf_end),
    .i_app_wdf_mask        (app_wdf_mask),
    .i_app_wdf_wren        (app_wdf_wren),
    .o_app_rd_data         (app_rd_data),
    .o_app_rd_data_end     (app_rd_data_end),
    .o_app_rd_data_valid   (app_rd_data_valid),
    .o_app_rdy             (app_rdy),
    .o_app_wdf_rdy         (app_wdf_rdy),
    .i_app_sr_req          (app_sr_req),
    .i_app_ref_req         (app_ref_req),
    .i_app_zq_req          (app_zq_req),
    .o_app_sr_active       (app_sr_active),
    .o_app_ref_ack         (app_ref_ack),
    .o_app_zq_ack          (app_zq_ack),
    .o_init_calib_complete (init_calib_complete),
    .o_dbg_maint_state     (dbg_maint_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // ---------------- read-return capture ----------------
  logic [127:0] got_q[$];
  int           got_cyc_q[$];
  int           end_err = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (app_rd_data_valid === 1'b1) begin
      got_q.push_back(app_rd_data);
      got_cyc_q.push_back(cyc);
    end
    if (app_rd_data_end !== app_rd_data_valid) end_err++;
  end

  // ---------------- reference model ----------------
  // Memory image plus the accepted-but-unexecuted traffic. Commands run in
  // order; a write needs a data beat, a read snapshots the image.
  typedef struct packed {
    logic       rd;
    logic [7:0] idx;
  } mcmd_t;

  logic [127:0] exp_mem [256];
  mcmd_t        cmd_q[$];
  logic [143:0] wd_q[$];
  logic [127:0] exp_q[$];

  function automatic void model_run();
    bit go = 1'b1;
    while (go && cmd_q.size() > 0) begin
      if (cmd_q[0].rd) begin
        exp_q.push_back(exp_mem[cmd_q[0].idx]);
        void'(cmd_q.pop_front());
      end else if (wd_q.size() > 0) begin
        for (int b = 0; b < 16; b++)
          if (!wd_q[0][128+b]) exp_mem[cmd_q[0].idx][8*b +: 8] = wd_q[0][8*b +: 8];
        void'(cmd_q.pop_front());
        void'(wd_q.pop_front());
      end else begin
        go = 1'b0;
      end
    end
  endfunction

  function automatic void model_flush();
    cmd_q.delete();
    wd_q.delete();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
  endfunction

  // ---------------- drivers ----------------
  task automatic step(input bit en, input logic [2:0] c, input logic [27:0] a,
                      input bit wren, input logic [127:0] d, input logic [15:0] m,
                      output bit acc_c, output bit acc_w);
    mcmd_t mc;
    @(negedge clk);
    app_en = en; app_cmd = c; app_addr = a;
    app_wdf_wren = wren; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = wren;
    acc_c = en && (app_rdy === 1'b1);
    acc_w = wren && (app_wdf_rdy === 1'b1);
    if (acc_c && c <= 3'd1) begin
      mc.rd  = (c == 3'd1);
      mc.idx = 8'((a >> 3) % 256);
      cmd_q.push_back(mc);
    end
    if (acc_w) wd_q.push_back({m, d});
    model_run();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit ac, aw;
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 28'd0, 1'b0, '0, '0, ac, aw);
  endtask

  task automatic cmd(input logic [2:0] c, input logic [27:0] a, output int acc_cyc);
    bit ac, aw;
    int n;
    ac = 1'b0;
    n = 0;
    while (!ac && n < 200) begin
      step(1'b1, c, a, 1'b0, '0, '0, ac, aw);
      n++;
    end
    acc_cyc = cyc;
    if (!ac) begin
      n_cmp++; n_fail++;
      $display("FAIL cmd_timeout: addr %h not accepted within 200 cycles", a);
    end
  endtask

  task automatic wdata(input logic [127:0] d, input logic [15:0] m);
    bit ac, aw;
    int n;
    aw = 1'b0;
    n = 0;
    while (!aw && n < 200) begin
      step(1'b0, 3'd0, 28'd0, 1'b1, d, m, ac, aw);
      n++;
    end
    if (!aw) begin
      n_cmp++; n_fail++;
      $display("FAIL wdf_timeout: beat not accepted within 200 cycles");
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    bit e;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({app_rd_data, app_rd_data_end, app_rd_data_valid, app_rdy, app_wdf_rdy,
         app_sr_active, app_ref_ack, app_zq_ack, init_calib_complete} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b wdf_rdy=%b calib=%b vld=%b, want all 0",
               app_rdy, app_wdf_rdy, init_calib_complete, app_rd_data_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= CALIB + 6; i++) begin
      @(posedge clk);
      #1;
      e = (i >= CALIB);
      n_cmp++;
      if ({init_calib_complete, app_rdy, app_wdf_rdy, app_sr_active} !== {e, e, e, 1'b0}) begin
        n_fail++;
        $display("FAIL calib_cycle %0d: got calib/rdy/wdf/sr=%b%b%b%b want %b%b%b0",
                 i, init_calib_complete, app_rdy, app_wdf_rdy, app_sr_active, e, e, e);
      end
    end
  endtask

  task automatic test_write_read();
    int t, acc;
    logic [127:0] d;
    d = 128'h0123456789ABCDEF0123456789ABCDEF;
    model_flush();
    wdata(d, 16'h0000);
    cmd(3'b000, 28'h10, t);
    cmd(3'b001, 28'h10, acc);
    idle(12);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_fail++;
      $display("FAIL wr_rd_pulses: got %0d valid cycles want 1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== d) begin
        n_fail++;
        $display("FAIL wr_rd_data: got %h want %h", got_q[0], d);
      end
      n_cmp++;
      if (got_cyc_q[0] - acc != 1 + RD_LAT) begin
        n_fail++;
        $display("FAIL wr_rd_latency: got %0d want %0d", got_cyc_q[0] - acc, 1 + RD_LAT);
      end
    end
    n_cmp++;
    if (end_err != 0) begin
      n_fail++;
      $display("FAIL rd_end_eq_valid: got %0d disagreeing cycles want 0", end_err);
    end
  endtask

  task automatic test_byte_mask();
    int t;
    model_flush();
    wdata({128{1'b1}}, 16'h0000);
    cmd(3'b000, 28'h20, t);
    wdata('0, 16'h00FF);
    cmd(3'b000, 28'h20, t);
    cmd(3'b001, 28'h20, t);
    idle(12);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_fail++;
      $display("FAIL mask_pulses: got %0d want 1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF) begin
        n_fail++;
        $display("FAIL mask_data: got %h want 0000000000000000FFFFFFFFFFFFFFFF", got_q[0]);
      end
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL mask_model: got %h want %h", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_data_before_cmd();
    logic [127:0] beats [4];
    logic [127:0] e_alias;
    int t;
    model_flush();
    for (int i = 0; i < 4; i++) begin
      beats[i] = rnd128();
      wdata(beats[i], 16'h0000);
    end
    n_cmp++;
    if (app_wdf_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL wdf_full_rdy: got %b want 0", app_wdf_rdy);
    end
    for (int i = 0; i < 4; i++) cmd(3'b000, 28'(8 * i), t);
    for (int i = 0; i < 4; i++) cmd(3'b001, 28'(8 * i), t);
    e_alias = rnd128();
    wdata(e_alias, 16'h0000);
    cmd(3'b000, 28'h800, t);
    cmd(3'b001, 28'h000, t);
    idle(16);
    n_cmp++;
    if (got_q.size() != 5) begin
      n_fail++;
      $display("FAIL dbc_count: got %0d reads want 5", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got_q[i] !== beats[i]) begin
          n_fail++;
          $display("FAIL dbc_data %0d: got %h want %h", i, got_q[i], beats[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        n_cmp++;
        if (got_cyc_q[i] != got_cyc_q[0] + i) begin
          n_fail++;
          $display("FAIL back_to_back %0d: got cycle %0d want %0d", i, got_cyc_q[i], got_cyc_q[0] + i);
        end
      end
      n_cmp++;
      if (got_q[4] !== e_alias) begin
        n_fail++;
        $display("FAIL alias_data: got %h want %h", got_q[4], e_alias);
      end
    end
  endtask

  task automatic test_maint();
    int ref_first, ref_cnt, zq_first, zq_cnt, rdy_low, wdf_low;
    ref_first = -1; zq_first = -1;
    ref_cnt = 0; zq_cnt = 0; rdy_low = 0; wdf_low = 0;
    idle(2);
    @(negedge clk);
    app_ref_req = 1'b1;
    app_zq_req  = 1'b1;
    for (int k = 0; k <= 45; k++) begin
      if (k > 0) begin
        // A second pair of requests during the ref busy period must merge.
        @(negedge clk);
        app_ref_req = (k == 5);
        app_zq_req  = (k == 5);
      end
      @(posedge clk);
      #1;
      if (app_ref_ack === 1'b1) begin ref_cnt++; if (ref_first < 0) ref_first = k; end
      if (app_zq_ack === 1'b1)  begin zq_cnt++;  if (zq_first < 0)  zq_first = k; end
      if (app_rdy !== 1'b1) rdy_low++;
      if (app_wdf_rdy !== 1'b1) wdf_low++;
    end
    n_cmp++;
    if (ref_first != 1 + MAINT || ref_cnt != 1) begin
      n_fail++;
      $display("FAIL ref_ack: got at %0d x%0d want at %0d x1", ref_first, ref_cnt, 1 + MAINT);
    end
    n_cmp++;
    if (zq_first != 1 + 2 * MAINT || zq_cnt != 1) begin
      n_fail++;
      $display("FAIL zq_ack: got at %0d x%0d want at %0d x1", zq_first, zq_cnt, 1 + 2 * MAINT);
    end
    n_cmp++;
    if (rdy_low != 1 + 2 * MAINT) begin
      n_fail++;
      $display("FAIL maint_rdy_low: got %0d cycles want %0d", rdy_low, 1 + 2 * MAINT);
    end
    n_cmp++;
    if (wdf_low != 0 || app_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL maint_wdf_rdy: got wdf_low=%0d final rdy=%b want 0 and 1", wdf_low, app_rdy);
    end
  endtask

  task automatic test_random();
    int t, guard;
    bit ac, aw, en, wren;
    logic [2:0]  c;
    logic [27:0] a;
    logic [15:0] m;
    int pick;
    model_flush();
    for (int w = 0; w < 16; w++) begin
      wdata(rnd128(), 16'h0000);
      cmd(3'b000, 28'(8 * w), t);
    end
    for (int i = 0; i < 120; i++) begin
      en   = ($urandom_range(0, 1) == 1);
      wren = ($urandom_range(0, 1) == 1);
      pick = $urandom_range(0, 5);
      c = (pick < 2) ? 3'(pick) : (pick < 5) ? 3'(pick % 2) : 3'($urandom_range(2, 7));
      a = 28'((($urandom & 32'h1FFFF) << 11) | ($urandom_range(0, 15) << 3) | $urandom_range(0, 7));
      m = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      step(en, c, a, wren, rnd128(), m, ac, aw);
    end
    // Leave both FIFOs empty so later tests start clean.
    guard = 0;
    while ((cmd_q.size() > 0 || wd_q.size() > 0) && guard < 50) begin
      if (wd_q.size() > 0) cmd(3'b000, 28'h640, t);
      else wdata(rnd128(), 16'h0000);
      guard++;
    end
    idle(24);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d reads want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_data %0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (end_err != 0) begin
      n_fail++;
      $display("FAIL rand_end_eq_valid: got %0d disagreeing cycles want 0", end_err);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    bit e;
    logic [127:0] keep;
    model_flush();
    keep = exp_mem[2];
    for (int i = 0; i < 3; i++) cmd(3'b001, 28'h10, t);
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    app_en = 1'b0;
    model_flush();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({app_rd_data_valid, app_rdy, app_wdf_rdy, init_calib_complete} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got vld/rdy/wdf/calib=%b%b%b%b want 0000",
               app_rd_data_valid, app_rdy, app_wdf_rdy, init_calib_complete);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= CALIB + 2; i++) begin
      @(posedge clk);
      #1;
      e = (i >= CALIB);
      n_cmp++;
      if ({init_calib_complete, app_rdy, app_wdf_rdy} !== {e, e, e}) begin
        n_fail++;
        $display("FAIL recal_cycle %0d: got %b%b%b want %b%b%b", i,
                 init_calib_complete, app_rdy, app_wdf_rdy, e, e, e);
      end
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL dropped_reads: got %0d valid pulses want 0", got_q.size());
    end
    cmd(3'b001, 28'h10, t);
    idle(12);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== keep) begin
      n_fail++;
      $display("FAIL mem_kept: got %0d reads first %h want 1 read %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 128'h0, keep);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_data_before_cmd();
    test_maint();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mig7_ui_model.md
Name: mig7_ui_model

Overview:
- Synthesizable responder for the MIG7 user (app_*) interface, backed by a small on-chip memory.
- Used in place of the mig7series controller for bring-up, for simulation, and on boards without DDR3.
- Drives the same handshakes, calibration status and refresh/ZQ acknowledges that the mig7_stub initiator expects, so the initiator can be verified without a memory model.

Parameters:
- MEM_AW, 8, log2 of memory depth in 128-bit words.
- CALIB_CYCLES, 64, cycles from reset release to init_calib_complete.
- RD_LATENCY, 4, read pipeline delay after issue, minimum 2.
- CMD_DEPTH, 4, command FIFO depth (power of 2).
- WDF_DEPTH, 4, write-data FIFO depth (power of 2).
- MAINT_CYCLES, 16, refresh/ZQ busy duration.
- STALL_PERIOD, 0, if nonzero app_rdy is forced low one cycle in every STALL_PERIOD.

Ports:
- clk  in  1  UI clock
- rst_n  in  1  asynchronous reset, active low
- app_addr  in  28  command address
- app_cmd  in  3  000 write, 001 read
- app_en  in  1  command valid
- app_wdf_data  in  128  write data
- app_wdf_end  in  1  last beat, ignored (single-beat BL8)
- app_wdf_mask  in  16  byte mask, 1 = byte not written
- app_wdf_wren  in  1  write data valid
- app_rd_data  out  128  read data
- app_rd_data_end  out  1  equals app_rd_data_valid
- app_rd_data_valid  out  1  read data valid
- app_rdy  out  1  command accept
- app_wdf_rdy  out  1  write data accept
- app_sr_req  in  1  unsupported, ignored
- app_ref_req  in  1  refresh request
- app_zq_req  in  1  ZQ calibration request
- app_sr_active  out  1  constant 0
- app_ref_ack  out  1  refresh done pulse
- app_zq_ack  out  1  ZQ done pulse
- init_calib_complete  out  1  calibration done

Behaviour:
- Reset:
  - All outputs 0; FIFOs, pipeline and maintenance state flushed; calibration counter restarts.
  - Memory contents are not cleared.
  - Reset asserted mid-operation drops in-flight reads with no valid pulse.
- Calibration:
  - Counter runs from reset release; init_calib_complete rises after CALIB_CYCLES cycles and stays high until reset.
  - app_rdy and app_wdf_rdy are 0 before calibration completes.
- Command accept and command FIFO:
  - A command is accepted on app_en & app_rdy.
  - app_rdy = calib & command FIFO not full & no maintenance busy/pending & not a stall cycle.
  - Codes other than 000/001 are accepted and discarded.
- Addressing:
  - Word index = app_addr[MEM_AW+2:3]; app_addr[2:0] is ignored.
  - Upper bits are ignored, so addresses alias modulo 2^MEM_AW words.
- Write-data FIFO:
  - A beat {data, mask} is pushed on app_wdf_wren & app_wdf_rdy.
  - app_wdf_rdy = calib & write-data FIFO not full.
  - Data may precede its command by up to WDF_DEPTH beats; a command may precede its data.
- Executor:
  - Strictly in order, at most one command per cycle.
  - Read: memory read issued immediately.
  - Write: stalls at the FIFO head until write data is available, then commits bytes whose mask bit is 0.
  - A read following a write observes that write.
- Latency:
  - With idle FIFOs, a read accepted at edge N gives app_rd_data_valid = app_rd_data_end = 1 for exactly one cycle after edge N+1+RD_LATENCY.
  - Read results return in command order.
  - Back-to-back reads give back-to-back valid cycles.
- Maintenance:
  - app_ref_req / app_zq_req are sampled only after calibration; each sets a sticky pending flag.
  - Maintenance starts once the command FIFO and executor are idle.
  - Busy lasts MAINT_CYCLES cycles, then a one-cycle ack.
  - Ref and ZQ pending together: ref runs first, then ZQ.
  - A request arriving while the same type is pending or busy merges, giving a single ack.
  - app_rdy is 0 while any maintenance is pending or busy; app_wdf_rdy is unaffected.
- Stall: when STALL_PERIOD > 0, a free-running counter forces app_rdy low on its terminal count.

Test Plan:
- Calibration: release rst_n -> init_calib_complete, app_rdy and app_wdf_rdy stay 0 for 64 cycles, then 1; app_sr_active 0 throughout.
- Write then read: write addr 0x10 data 0x0123..CDEF with mask 0, then read 0x10 -> app_rd_data = 0x0123..CDEF; valid and end high for exactly one cycle, 5 cycles after read accept.
- Byte mask: write all-F with mask 0, then write data 0 with mask 0x00FF -> read returns 0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF.
- Data before command: push 4 wdf beats A,B,C,D -> app_wdf_rdy drops to 0; then write cmds to addrs 0, 8, 16, 24 and read each back -> A,B,C,D in order; also write addr 0x800 then read addr 0 -> same data (alias).
- Maintenance: pulse app_ref_req and app_zq_req in the same cycle with idle queues -> app_rdy 0, app_ref_ack pulse 17 cycles later, app_zq_ack 16 cycles after that, then app_rdy returns to 1.
- Reset mid-operation: issue 3 reads, assert rst_n low 2 cycles after -> no app_rd_data_valid pulse; calibration restarts and takes 64 cycles.
